// File: rtl/pwm_sample_if.sv
// Valid/ready handshake carrying duty samples from the filter path into the carrier generator.
interface pwm_sample_if #(
    parameter int WIDTH = 11
);
    logic [WIDTH-1:0] sample_in;
    logic             sample_valid;
    logic             sample_ready;

    modport master (output sample_in, output sample_valid, input sample_ready);
    modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/pwm_carrier_gen.sv
// Carrier ramp (sawtooth or triangle) plus period-synchronous, double-buffered duty word
// for the downstream PWM comparator.
module pwm_carrier_gen #(
    parameter int WIDTH       = 11,
    parameter int DEFAULT_TOP = 2000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode_in,
    input  logic [WIDTH-1:0] top_in,
    pwm_sample_if.slave      smp,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] C,
    output logic             period_start
);
    localparam logic [WIDTH-1:0] TOP_RESET = WIDTH'(DEFAULT_TOP);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);

    // ST_IDLE doubles as run_q = 0; ST_UP/ST_DOWN carry the triangle direction.
    typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic [WIDTH-1:0] c_reg, c_next;
    logic [WIDTH-1:0] top_reg, top_next;
    logic             mode_reg, mode_next;
    logic [WIDTH-1:0] shadow_reg, shadow_next;
    logic             shadow_full_reg, shadow_full_next;
    logic             pstart_reg, pstart_next;

    logic             load_now;
    logic             accept;
    logic [WIDTH-1:0] top_clamped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            r_reg           <= '0;
            c_reg           <= '0;
            top_reg         <= TOP_RESET;
            mode_reg        <= 1'b0;
            shadow_reg      <= '0;
            shadow_full_reg <= 1'b0;
            pstart_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            r_reg           <= r_next;
            c_reg           <= c_next;
            top_reg         <= top_next;
            mode_reg        <= mode_next;
            shadow_reg      <= shadow_next;
            shadow_full_reg <= shadow_full_next;
            pstart_reg      <= pstart_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        r_next           = r_reg;
        c_next           = c_reg;
        top_next         = top_reg;
        mode_next        = mode_reg;
        shadow_next      = shadow_reg;
        shadow_full_next = shadow_full_reg;
        pstart_next      = 1'b0;

        top_clamped = (top_in < TWO) ? TWO : top_in;

        // A new period begins on start, on a sawtooth wrap, or at the triangle valley.
        load_now = en && ((state_reg == ST_IDLE) ||
                          (!mode_reg && r_reg == top_reg) ||
                          (mode_reg && state_reg == ST_DOWN && r_reg == ONE));

        smp.sample_ready = !shadow_full_reg || load_now;
        accept           = smp.sample_valid && smp.sample_ready;

        if (!en) begin
            state_next = ST_IDLE;
            r_next     = '0;
        end else if (load_now) begin
            state_next  = ST_UP;
            r_next      = '0;
            top_next    = top_clamped;
            mode_next   = mode_in;
            pstart_next = 1'b1;
            if (shadow_full_reg) begin
                c_next           = (shadow_reg > top_clamped) ? top_clamped : shadow_reg;
                shadow_full_next = 1'b0;
            end
        end else if (!mode_reg) begin
            r_next = r_reg + ONE;
        end else if (state_reg == ST_UP) begin
            if (r_reg == top_reg) begin
                r_next     = top_reg - ONE;
                state_next = ST_DOWN;
            end else begin
                r_next = r_reg + ONE;
            end
        end else begin
            r_next = r_reg - ONE;
        end

        // An accepted sample refills the shadow even on the edge that drains it.
        if (accept) begin
            shadow_next      = smp.sample_in;
            shadow_full_next = 1'b1;
        end
    end

    assign R            = r_reg;
    assign C            = c_reg;
    assign period_start = pstart_reg;
endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Directed bench: table of per-cycle vectors for the carrier shapes, then hand sequences
// for handshake, clamping, enable drop and asynchronous reset.
module tb_pwm_carrier_gen;
    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         mode_in = 1'b0;
    logic [W-1:0] top_in = '0;
    logic [W-1:0] R, C;
    logic         period_start;

    int n_checks = 0;
    int n_errors = 0;

    pwm_sample_if #(.WIDTH(W)) sif ();

    pwm_carrier_gen #(.WIDTH(W), .DEFAULT_TOP(2000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode_in      (mode_in),
        .top_in       (top_in),
        .smp          (sif),
        .R            (R),
        .C            (C),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic         mode;
        logic [W-1:0] top;
        logic [W-1:0] exp_r;
        logic [W-1:0] exp_c;
        logic         exp_ps;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        sif.sample_valid = 1'b0;
        sif.sample_in    = '0;

        vecs[0]  = '{1, 0, 4, 0, 0, 1};
        vecs[1]  = '{1, 0, 4, 1, 0, 0};
        vecs[2]  = '{1, 0, 4, 2, 0, 0};
        vecs[3]  = '{1, 0, 4, 3, 0, 0};
        vecs[4]  = '{1, 0, 4, 4, 0, 0};
        vecs[5]  = '{1, 0, 4, 0, 0, 1};
        vecs[6]  = '{1, 0, 4, 1, 0, 0};
        vecs[7]  = '{0, 0, 4, 0, 0, 0};
        vecs[8]  = '{1, 1, 3, 0, 0, 1};
        vecs[9]  = '{1, 1, 3, 1, 0, 0};
        vecs[10] = '{1, 1, 3, 2, 0, 0};
        vecs[11] = '{1, 1, 3, 3, 0, 0};
        vecs[12] = '{1, 1, 3, 2, 0, 0};
        vecs[13] = '{1, 1, 3, 1, 0, 0};
        vecs[14] = '{1, 1, 3, 0, 0, 1};
        vecs[15] = '{1, 1, 3, 1, 0, 0};
        vecs[16] = '{1, 1, 3, 2, 0, 0};
        vecs[17] = '{1, 1, 3, 3, 0, 0};
        vecs[18] = '{1, 1, 3, 2, 0, 0};

        // Reset state
        step(2);
        chk("reset_R", int'(R), 0);
        chk("reset_C", int'(C), 0);
        chk("reset_ready", int'(sif.sample_ready), 1);
        chk("reset_ps", int'(period_start), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            en = vecs[i].en; mode_in = vecs[i].mode; top_in = vecs[i].top;
            step(1);
            $display("vec %0d: R=%0d C=%0d ps=%0d", i, R, C, period_start);
            chk($sformatf("vec%0d_R", i), int'(R), int'(vecs[i].exp_r));
            chk($sformatf("vec%0d_C", i), int'(C), int'(vecs[i].exp_c));
            chk($sformatf("vec%0d_ps", i), int'(period_start), int'(vecs[i].exp_ps));
        end

        // Sample 7 pushed mid-period, applied at the wrap
        en = 1'b0; step(1);
        en = 1'b1; mode_in = 1'b0; top_in = 11'd10; step(1);
        chk("saw10_start_R", int'(R), 0);
        step(5);
        sif.sample_valid = 1'b1; sif.sample_in = 11'd7;
        chk("push7_ready_before", int'(sif.sample_ready), 1);
        step(1);
        sif.sample_valid = 1'b0;
        $display("push 7: R=%0d ready=%0d", R, sif.sample_ready);
        chk("push7_ready_after", int'(sif.sample_ready), 0);
        chk("push7_C_held", int'(C), 0);
        step(4);
        chk("push7_R_top", int'(R), 10);
        chk("push7_C_before_wrap", int'(C), 0);
        chk("push7_ready_at_L", int'(sif.sample_ready), 1);
        step(1);
        chk("push7_C_applied", int'(C), 7);
        chk("push7_ps", int'(period_start), 1);
        chk("push7_ready_empty", int'(sif.sample_ready), 1);

        // Push 5, then hold 9 against a full shadow
        sif.sample_valid = 1'b1; sif.sample_in = 11'd5; step(1);
        sif.sample_in = 11'd9;
        chk("hold9_ready_full", int'(sif.sample_ready), 0);
        step(8);
        chk("hold9_ready_R9", int'(sif.sample_ready), 0);
        step(1);
        chk("hold9_ready_at_L", int'(sif.sample_ready), 1);
        step(1);
        sif.sample_valid = 1'b0;
        $display("wrap with 9 held: R=%0d C=%0d", R, C);
        chk("hold9_C5", int'(C), 5);
        chk("hold9_shadow_refilled", int'(sif.sample_ready), 0);
        step(10);
        chk("hold9_C5_still", int'(C), 5);
        step(1);
        chk("hold9_C9", int'(C), 9);
        chk("hold9_ready_empty", int'(sif.sample_ready), 1);

        // Duty 20 saturates to top 6; then top 0 clamps to 2
        sif.sample_valid = 1'b1; sif.sample_in = 11'd20; step(1);
        sif.sample_valid = 1'b0; top_in = 11'd6;
        step(10);
        chk("sat_R0", int'(R), 0);
        chk("sat_C6", int'(C), 6);
        chk("sat_ps", int'(period_start), 1);
        top_in = 11'd0;
        step(6);
        chk("top6_R6", int'(R), 6);
        step(1);
        chk("top0_R0", int'(R), 0);
        step(1); chk("top0_R1", int'(R), 1);
        step(1); chk("top0_R2", int'(R), 2);
        step(1); chk("top0_wrap_R", int'(R), 0);
        chk("top0_wrap_ps", int'(period_start), 1);
        chk("top0_C_held", int'(C), 6);
        step(1); chk("top0_R1b", int'(R), 1);

        // Enable drop at R = 7
        top_in = 11'd10;
        step(2);
        chk("top10_L_R", int'(R), 0);
        step(7);
        chk("endrop_R7", int'(R), 7);
        en = 1'b0; step(1);
        $display("en drop: R=%0d C=%0d ps=%0d", R, C, period_start);
        chk("endrop_R", int'(R), 0);
        chk("endrop_ps", int'(period_start), 0);
        chk("endrop_C", int'(C), 6);
        sif.sample_valid = 1'b1; sif.sample_in = 11'd3;
        chk("endrop_ready", int'(sif.sample_ready), 1);
        step(1);
        sif.sample_valid = 1'b0;
        chk("endrop_full", int'(sif.sample_ready), 0);
        chk("endrop_C_held", int'(C), 6);
        en = 1'b1; step(1);
        chk("restart_R", int'(R), 0);
        chk("restart_ps", int'(period_start), 1);
        chk("restart_C3", int'(C), 3);

        // Asynchronous reset mid-period with the shadow full
        sif.sample_valid = 1'b1; sif.sample_in = 11'd8; step(1);
        sif.sample_valid = 1'b0;
        step(2);
        chk("prereset_R3", int'(R), 3);
        chk("prereset_full", int'(sif.sample_ready), 0);
        rst_n = 1'b0;
        #1;
        $display("async reset: R=%0d C=%0d ready=%0d", R, C, sif.sample_ready);
        chk("areset_R", int'(R), 0);
        chk("areset_C", int'(C), 0);
        chk("areset_ready", int'(sif.sample_ready), 1);
        chk("areset_ps", int'(period_start), 0);
        chk("areset_top", int'(dut.top_reg), 2000);
        step(1);
        rst_n = 1'b1;
        step(1);
        chk("postreset_R", int'(R), 0);
        chk("postreset_ps", int'(period_start), 1);
        chk("postreset_C_discarded", int'(C), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pwm_carrier_gen.md
Name: pwm_carrier_gen

Overview:
Upstream stage of the PWM comparator. Generates the WIDTH-bit carrier ramp (R) and the period-synchronous duty word (C) that the comparator consumes.
- Carrier is either a sawtooth or a symmetric triangle.
- The duty sample from the ANC filter path arrives over a valid/ready handshake. It is double-buffered and applied only at period boundaries, so the comparator never sees a mid-period duty change.

Parameters:
WIDTH, 11, bit width of carrier, duty and top values
DEFAULT_TOP, 2000, active top value after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low holds the carrier at 0
mode_in  in  1  0 = sawtooth, 1 = triangle; sampled only at load edges
top_in  in  WIDTH  requested carrier top; sampled only at load edges
sample_in  in  WIDTH  duty sample
sample_valid  in  1  sample_in valid
sample_ready  out  1  shadow register can accept a sample
R  out  WIDTH  carrier count, registered
C  out  WIDTH  active duty word, registered
period_start  out  1  one-cycle pulse, high in the first cycle of each period (R == 0)

Behaviour:
Reset (async, rst_n low), all values registered:
- R = 0, dir = up, run_q = 0.
- C = 0, top_active = DEFAULT_TOP, mode_active = 0.
- Shadow register empty; sample_ready = 1; period_start = 0.

Load edge L (a clock edge where the new period begins; R is 0 afterwards):
- start: en = 1 and run_q = 0. R stays 0; run_q is set.
- sawtooth wrap: en = 1, run_q = 1, mode_active = 0, R == top_active.
- triangle wrap: en = 1, run_q = 1, mode_active = 1, dir = down, R == 1.

At every L:
- top_active <= max(top_in, 2).
- mode_active <= mode_in; dir <= up.
- If the shadow is full: C <= min(shadow, new top_active) and the shadow empties.
- If the shadow is empty: C holds its previous value.
- period_start <= 1 on L, 0 on every other edge.

Counting (en = 1, run_q = 1, not L):
- Sawtooth: R increments by 1. Period is top_active + 1 cycles.
- Triangle: R increments while dir = up. When R == top_active with dir = up: R <= top_active - 1 and dir <= down. While dir = down, R decrements. Period is 2*top_active cycles. Sequence with top = 3: 0,1,2,3,2,1,0,...

Enable low:
- Next edge: R <= 0, dir <= up, run_q <= 0, period_start <= 0.
- C and top_active hold. The shadow still accepts samples.
- Re-assertion of en produces a start edge (an L).

Handshake:
- sample_ready = !shadow_full || L_now, where L_now is the combinational L condition.
- Transfer occurs on a rising edge with sample_valid & sample_ready; sample_in is written to the shadow.
- Accept and consume in the same edge: the old shadow goes to C and the new sample becomes the shadow (shadow stays full).
- Holding sample_valid with sample_ready = 0 loses nothing; the upstream holds sample_in stable.

Arithmetic:
- All compares are unsigned WIDTH-bit.
- top_in values 0 and 1 are clamped to 2.
- Duty greater than top_active saturates to top_active (100% on). No wrap-around is possible because R never exceeds top_active.

Reset mid-period: immediately returns to the reset values; a pending shadow sample is discarded.

Test Plan:
- Reset, then en = 1, mode 0, top_in = 4 → R = 0,1,2,3,4,0,1...; period_start high on each R = 0 (every 5 cycles); C = 0.
- Mode 1, top_in = 3 → R = 0,1,2,3,2,1,0,1...; period 6 cycles; period_start only at R = 0 valleys, never at the peak.
- Sawtooth top = 10; push sample 7 mid-period → sample_ready falls the next cycle; C stays at its old value until the wrap, then C = 7 and sample_ready = 1.
- Push 5, then hold sample_valid with 9 while the shadow is full → at the wrap: C = 5, 9 accepted on the same edge; next wrap: C = 9.
- top_in = 6 with sample 20 → C = 6 after load. top_in = 0 → top_active = 2 and the sawtooth sequence is 0,1,2,0.
- Drop en at R = 7 → R = 0, period_start = 0, C held. Assert rst_n = 0 mid-period with the shadow full → C = 0, R = 0, sample_ready = 1, top_active = 2000 asynchronously.
